// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard/sequencing
// controller. The master side owns the Decode/Execute/Memory fields; the
// slave side (the controller) owns the enables, flushes and mult/div status.
interface pipeline_ctrl_if;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic       branchD;
  logic       jrD;
  logic       branch_takenD;
  logic       md_useD;
  logic [4:0] writeregE;
  logic       regwriteE;
  logic       memtoregE;
  logic [4:0] writeregM;
  logic       memtoregM;
  logic       md_startE;
  logic       md_divE;

  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       md_busy;
  logic       md_done;

  modport master (
    output rsD, rtD, branchD, jrD, branch_takenD, md_useD,
           writeregE, regwriteE, memtoregE, writeregM, memtoregM,
           md_startE, md_divE,
    input  pc_en, ifid_en, ifid_flush, idex_flush, md_busy, md_done
  );

  modport slave (
    input  rsD, rtD, branchD, jrD, branch_takenD, md_useD,
           writeregE, regwriteE, memtoregE, writeregM, memtoregM,
           md_startE, md_divE,
    output pc_en, ifid_en, ifid_flush, idex_flush, md_busy, md_done
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Stalls Decode on load-use, branch/jr operand and HI/LO-busy hazards and
// owns the busy counter of the multi-cycle mult/div unit.
// Optional: define PIPELINE_CTRL_BRANCH_FLUSH_EN to squash the instruction
// fetched after a taken branch/jump (no delay slot); otherwise ifid_flush is 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | mult/div unit free; a md_startE loads the cycle count
// BUSY  | mult/div in flight; cnt counts down, leaving on cnt==1
module pipeline_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic             busy;

  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic stall;

  // Register index 0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] dst,
                                   input logic [4:0] a,
                                   input logic [4:0] b);
    return (dst != 5'd0) && ((dst == a) || (dst == b));
  endfunction

  assign busy = (state == BUSY);

  // Hazard detection: any one of the three terms freezes PC/if_id and bubbles id_ex.
  always_comb begin
    lw_stall = bus.memtoregE & bus.regwriteE & reg_hit(bus.writeregE, bus.rsD, bus.rtD);
    br_stall = (bus.branchD | bus.jrD) &
               ((bus.regwriteE & reg_hit(bus.writeregE, bus.rsD, bus.rtD)) |
                (bus.memtoregM & reg_hit(bus.writeregM, bus.rsD, bus.rtD)));
    // md_startE is included so a consumer right behind the mult/div waits
    // even though busy only rises on the following cycle.
    md_stall = bus.md_useD & (busy | bus.md_startE);
    stall    = lw_stall | br_stall | md_stall;
  end

  assign bus.pc_en      = ~stall;
  assign bus.ifid_en    = ~stall;
  assign bus.idex_flush = stall;
`ifdef PIPELINE_CTRL_BRANCH_FLUSH_EN
  // A stall takes priority; the branch is re-evaluated once Decode advances.
  assign bus.ifid_flush = bus.branch_takenD & ~stall;
`else
  assign bus.ifid_flush = 1'b0;
`endif
  assign bus.md_busy    = busy;
  assign bus.md_done    = done_q;

  // Mult/div busy sequencer: load count on start, count down, pulse done on exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.md_startE) begin
            cnt   <= bus.md_divE ? DIV_LOAD : MULT_LOAD;
            state <= BUSY;
          end
        end
        BUSY: begin
          // A start seen here is illegal (md_stall prevents it) and is ignored.
          if (cnt == CNT_ONE) begin
            cnt    <= '0;
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic against a timestamp-based model of the mult/div unit.
module tb_pipeline_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: an accepted operation occupies cycles [m_start, m_start+m_len)
  // and its done pulse appears in cycle m_start+m_len.
  int cyc     = 0;
  bit m_valid = 1'b0;
  int m_start = 0;
  int m_len   = 0;

  function automatic bit m_busy(int c);
    return m_valid && (c >= m_start) && (c < m_start + m_len);
  endfunction

  function automatic bit m_done(int c);
    return m_valid && (c == m_start + m_len);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0;
    end else begin
      if (bus.md_startE && !m_busy(cyc)) begin
        m_valid <= 1'b1;
        m_start <= cyc + 1;
        m_len   <= bus.md_divE ? DIV_N : MULT_N;
      end
      cyc <= cyc + 1;
    end
  end

  function automatic bit dep(logic [4:0] dst, logic [4:0] a, logic [4:0] b);
    return (dst != 0) && (dst == a || dst == b);
  endfunction

  function automatic bit exp_stall();
    bit lw, br, md;
    lw = bus.memtoregE && bus.regwriteE && dep(bus.writeregE, bus.rsD, bus.rtD);
    br = (bus.branchD || bus.jrD) &&
         ((bus.regwriteE && dep(bus.writeregE, bus.rsD, bus.rtD)) ||
          (bus.memtoregM && dep(bus.writeregM, bus.rsD, bus.rtD)));
    md = bus.md_useD && (m_busy(cyc) || bus.md_startE);
    return lw || br || md;
  endfunction

  function automatic bit exp_flush();
`ifdef PIPELINE_CTRL_BRANCH_FLUSH_EN
    return bus.branch_takenD && !exp_stall();
`else
    return 1'b0;
`endif
  endfunction

  task automatic clear_inputs();
    bus.rsD = 0; bus.rtD = 0; bus.branchD = 0; bus.jrD = 0;
    bus.branch_takenD = 0; bus.md_useD = 0;
    bus.writeregE = 0; bus.regwriteE = 0; bus.memtoregE = 0;
    bus.writeregM = 0; bus.memtoregM = 0;
    bus.md_startE = 0; bus.md_divE = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.md_busy !== 1'b0) begin n_err++; $display("FAIL reset_md_busy got=%b exp=0", bus.md_busy); end
    n_cmp++; if (bus.md_done !== 1'b0) begin n_err++; $display("FAIL reset_md_done got=%b exp=0", bus.md_done); end
    n_cmp++; if ({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush} !== 4'b1100) begin
      n_err++; $display("FAIL reset_ctrl got=%b exp=1100", {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    @(negedge clk); clear_inputs();
    bus.memtoregE = 1; bus.regwriteE = 1; bus.writeregE = 8; bus.rsD = 8; #1;
    n_cmp++; if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b001) begin
      n_err++; $display("FAIL lw_rs got=%b exp=001", {bus.pc_en, bus.ifid_en, bus.idex_flush});
    end
    @(negedge clk); bus.rsD = 3; bus.rtD = 8; #1;
    n_cmp++; if (bus.pc_en !== 1'b0) begin n_err++; $display("FAIL lw_rt pc_en got=%b exp=0", bus.pc_en); end
    @(negedge clk); bus.writeregE = 0; bus.rsD = 0; bus.rtD = 0; #1;
    n_cmp++; if ({bus.pc_en, bus.idex_flush} !== 2'b10) begin
      n_err++; $display("FAIL lw_r0 got=%b exp=10", {bus.pc_en, bus.idex_flush});
    end
    @(negedge clk); bus.regwriteE = 0; bus.writeregE = 8; bus.rsD = 8; #1;
    n_cmp++; if (bus.pc_en !== 1'b1) begin n_err++; $display("FAIL lw_no_regwrite pc_en got=%b exp=1", bus.pc_en); end
  endtask

  task automatic test_branch();
    @(negedge clk); clear_inputs();
    bus.branchD = 1; bus.rtD = 9; bus.regwriteE = 1; bus.writeregE = 9; #1;
    n_cmp++; if ({bus.pc_en, bus.idex_flush} !== 2'b01) begin
      n_err++; $display("FAIL br_alu got=%b exp=01", {bus.pc_en, bus.idex_flush});
    end
    @(negedge clk); bus.regwriteE = 0; bus.writeregE = 0; bus.memtoregM = 1; bus.writeregM = 9; #1;
    n_cmp++; if ({bus.pc_en, bus.idex_flush} !== 2'b01) begin
      n_err++; $display("FAIL br_load_m got=%b exp=01", {bus.pc_en, bus.idex_flush});
    end
    @(negedge clk); bus.memtoregM = 0; bus.writeregM = 0; #1;
    n_cmp++; if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b110) begin
      n_err++; $display("FAIL br_clear got=%b exp=110", {bus.pc_en, bus.ifid_en, bus.idex_flush});
    end
    @(negedge clk); bus.branchD = 0; bus.jrD = 1; bus.rsD = 31; bus.rtD = 0; bus.regwriteE = 1; bus.writeregE = 31; #1;
    n_cmp++; if (bus.pc_en !== 1'b0) begin n_err++; $display("FAIL jr_alu pc_en got=%b exp=0", bus.pc_en); end
    @(negedge clk); bus.regwriteE = 0; #1;
    n_cmp++; if (bus.pc_en !== 1'b1) begin n_err++; $display("FAIL jr_no_write pc_en got=%b exp=1", bus.pc_en); end
  endtask

  task automatic test_mult();
    @(negedge clk); clear_inputs();
    bus.md_useD = 1; bus.md_startE = 1; bus.md_divE = 0; #1;
    n_cmp++; if (bus.pc_en !== 1'b0) begin n_err++; $display("FAIL mult_start_stall pc_en got=%b exp=0", bus.pc_en); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); bus.md_startE = 0; #1;
      n_cmp++; if (bus.md_busy !== (i < MULT_N)) begin
        n_err++; $display("FAIL mult_busy cycle=%0d got=%b exp=%b", i, bus.md_busy, (i < MULT_N));
      end
      n_cmp++; if (bus.md_done !== (i == MULT_N)) begin
        n_err++; $display("FAIL mult_done cycle=%0d got=%b exp=%b", i, bus.md_done, (i == MULT_N));
      end
      n_cmp++; if (bus.pc_en !== (i >= MULT_N)) begin
        n_err++; $display("FAIL mult_stall cycle=%0d pc_en got=%b exp=%b", i, bus.pc_en, (i >= MULT_N));
      end
    end
  endtask

  task automatic test_div_back_to_back();
    int busy_cnt;
    bit saw_done;
    busy_cnt = 0;
    saw_done = 0;
    @(negedge clk); clear_inputs();
    bus.md_useD = 1; bus.md_startE = 1; bus.md_divE = 1; #1;
    n_cmp++; if (bus.idex_flush !== 1'b1) begin n_err++; $display("FAIL div_start_stall idex_flush got=%b exp=1", bus.idex_flush); end
    for (int i = 0; i < 60 && !saw_done; i++) begin
      @(negedge clk);
      bus.md_startE = (i == 3);
      bus.md_divE   = 1'b0;
      #1;
      if (bus.md_busy === 1'b1) busy_cnt++;
      if (bus.md_done === 1'b1) saw_done = 1;
    end
    n_cmp++; if (busy_cnt != DIV_N) begin n_err++; $display("FAIL div_busy_len got=%0d exp=%0d", busy_cnt, DIV_N); end
    n_cmp++; if (!saw_done) begin n_err++; $display("FAIL div_done_seen got=0 exp=1"); end
    @(negedge clk); bus.md_startE = 0; #1;
    n_cmp++; if ({bus.md_busy, bus.md_done} !== 2'b00) begin
      n_err++; $display("FAIL div_after got=%b exp=00", {bus.md_busy, bus.md_done});
    end
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk); clear_inputs();
    bus.md_startE = 1; bus.md_divE = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); bus.md_startE = 0;
    end
    #1;
    n_cmp++; if (bus.md_busy !== 1'b1) begin n_err++; $display("FAIL rst_div_pre busy got=%b exp=1", bus.md_busy); end
    #1; rst = 1'b0; #1;
    n_cmp++; if ({bus.md_busy, bus.md_done} !== 2'b00) begin
      n_err++; $display("FAIL rst_div_async got=%b exp=00", {bus.md_busy, bus.md_done});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++; if ({bus.md_busy, bus.md_done} !== 2'b00) begin
        n_err++; $display("FAIL rst_div_after cycle=%0d got=%b exp=00", i, {bus.md_busy, bus.md_done});
      end
    end
    @(negedge clk); bus.md_startE = 1; bus.md_divE = 0;
    @(negedge clk); bus.md_startE = 0; #1;
    n_cmp++; if (bus.md_busy !== 1'b1) begin n_err++; $display("FAIL rst_div_restart busy got=%b exp=1", bus.md_busy); end
    repeat (MULT_N + 1) @(negedge clk);
  endtask

  task automatic test_branch_flush();
    bit e;
    @(negedge clk); clear_inputs();
    bus.branchD = 1; bus.branch_takenD = 1; bus.rsD = 4; #1;
`ifdef PIPELINE_CTRL_BRANCH_FLUSH_EN
    e = 1'b1;
`else
    e = 1'b0;
`endif
    n_cmp++; if (bus.ifid_flush !== e) begin n_err++; $display("FAIL flush_taken got=%b exp=%b", bus.ifid_flush, e); end
    @(negedge clk); bus.memtoregE = 1; bus.regwriteE = 1; bus.writeregE = 4; #1;
    n_cmp++; if (bus.ifid_flush !== 1'b0) begin n_err++; $display("FAIL flush_stalled got=%b exp=0", bus.ifid_flush); end
    n_cmp++; if (bus.pc_en !== 1'b0) begin n_err++; $display("FAIL flush_stalled pc_en got=%b exp=0", bus.pc_en); end
  endtask

  task automatic test_random();
    bit s, f, b, d;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.rsD           = 5'($urandom_range(0, 3));
      bus.rtD           = 5'($urandom_range(0, 3));
      bus.branchD       = ($urandom_range(0, 3) == 0);
      bus.jrD           = ($urandom_range(0, 5) == 0);
      bus.branch_takenD = $urandom_range(0, 1) == 1;
      bus.md_useD       = ($urandom_range(0, 3) == 0);
      bus.writeregE     = 5'($urandom_range(0, 3));
      bus.regwriteE     = $urandom_range(0, 1) == 1;
      bus.memtoregE     = ($urandom_range(0, 2) == 0);
      bus.writeregM     = 5'($urandom_range(0, 3));
      bus.memtoregM     = ($urandom_range(0, 2) == 0);
      bus.md_startE     = ($urandom_range(0, 9) == 0);
      bus.md_divE       = ($urandom_range(0, 2) == 0);
      #1;
      s = exp_stall(); f = exp_flush(); b = m_busy(cyc); d = m_done(cyc);
      n_cmp++;
      if ({bus.pc_en, bus.ifid_en, bus.idex_flush, bus.ifid_flush, bus.md_busy, bus.md_done} !==
          {!s, !s, s, f, b, d}) begin
        n_err++;
        $display("FAIL rand cycle=%0d got=%b exp=%b", i,
                 {bus.pc_en, bus.ifid_en, bus.idex_flush, bus.ifid_flush, bus.md_busy, bus.md_done},
                 {!s, !s, s, f, b, d});
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mult();
    test_div_back_to_back();
    test_reset_mid_div();
    test_branch_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Drives the enable of the PC and of the if_id register, the flush of if_id, and the bubble-insert clear of id_ex.
- Detects load-use and branch/jr operand hazards.
- Owns the busy counter of the multi-cycle mult/div unit and stalls Decode while an HI/LO consumer waits on it.

Parameters:
- MULT_CYCLES, 5, cycles md_busy stays high for a mult/multu.
- DIV_CYCLES, 32, cycles md_busy stays high for a div/divu.
- CNT_W, 6, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- rsD  in  5  rs field of the instruction in Decode.
- rtD  in  5  rt field of the instruction in Decode.
- branchD  in  1  Decode holds a conditional branch (compares in Decode).
- jrD  in  1  Decode holds jr/jalr.
- branch_takenD  in  1  branch/jump in Decode resolves taken.
- md_useD  in  1  Decode holds mfhi/mflo/mthi/mtlo or a mult/div.
- writeregE  in  5  destination register in Execute.
- regwriteE  in  1  Execute writes the register file.
- memtoregE  in  1  Execute is a load.
- writeregM  in  5  destination register in Memory.
- memtoregM  in  1  Memory is a load.
- md_startE  in  1  Execute holds a mult/div this cycle.
- md_divE  in  1  qualifies md_startE: 1 = divide, 0 = multiply.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  if_id enable.
- ifid_flush  out  1  if_id synchronous clear.
- idex_flush  out  1  id_ex clear (bubble insert).
- md_busy  out  1  mult/div unit busy.
- md_done  out  1  one-cycle pulse when mult/div result is ready.

Behaviour:
- Hazard terms (combinational); a register match requires a nonzero index.
- lw_stall = memtoregE & regwriteE & (writeregE==rsD | writeregE==rtD).
- br_stall = (branchD|jrD) & ((regwriteE & writeregE∈{rsD,rtD}) | (memtoregM & writeregM∈{rsD,rtD})).
- md_stall = md_useD & (md_busy | md_startE). This covers an HI/LO consumer directly behind a mult/div.
- stall = lw_stall | br_stall | md_stall.
- On stall: pc_en=0, ifid_en=0, idex_flush=1.
- Otherwise: pc_en=1, ifid_en=1, idex_flush=0.
- ifid_flush: see Optional Feature. Never asserted while stall=1; the stall wins and the branch re-evaluates next cycle.
- Mult/div counter: 2-state FSM, IDLE / BUSY, with cnt[CNT_W-1:0].
- IDLE & md_startE: load cnt = md_divE ? DIV_CYCLES : MULT_CYCLES, go to BUSY. Latency: md_busy rises the cycle after the start edge.
- BUSY: cnt decrements each cycle. On cnt==1, next state is IDLE with cnt=0.
- md_busy = (state==BUSY). High exactly N cycles.
- md_done: registered; 1 in the first cycle after BUSY→IDLE, 0 otherwise.
- md_startE while BUSY is ignored (cannot occur legally because of md_stall); counter undisturbed.
- Reset (rst=0, any time, including mid-count): state=IDLE, cnt=0, md_busy=0, md_done=0. Takes effect immediately, not at the clock edge.
- With all inputs 0 during or after reset: pc_en=1, ifid_en=1, ifid_flush=0, idex_flush=0.
- Release of rst: first edge with rst=1 operates normally.

Optional Feature:
- Macro: PIPELINE_CTRL_BRANCH_FLUSH_EN.
- Defined: ifid_flush = branch_takenD & ~stall. Squashes the sequential instruction fetched after a taken branch/jump (no delay slot).
- Undefined: ifid_flush tied to 0 (MIPS delay-slot semantics); branch_takenD is unused.

Test Plan:
- Load-use: memtoregE=1, regwriteE=1, writeregE=8, rsD=8 → pc_en=0, ifid_en=0, idex_flush=1 for that cycle. With writeregE=0 and rsD=0 → no stall.
- Branch after ALU op: branchD=1, rtD=9, regwriteE=1, writeregE=9 → stall 1 cycle. Next cycle, memtoregM=1, writeregM=9 → stall again. Then clear → pc_en=1.
- Multiply: pulse md_startE=1, md_divE=0 → md_busy high exactly 5 cycles. md_done=1 in the 6th cycle only. md_useD=1 throughout → stall every busy cycle, released when md_done=1.
- Divide plus back-to-back consumer: md_startE=1, md_divE=1 with md_useD=1 in the same cycle → stall in the start cycle, then md_busy high for 32 cycles. A second md_startE during BUSY does not extend it.
- Reset mid-divide: rst=0 at busy cycle 10, asynchronously between edges → md_busy and md_done drop immediately. After release, md_busy=0 until a new md_startE.
- With PIPELINE_CTRL_BRANCH_FLUSH_EN: branch_takenD=1, no hazard → ifid_flush=1. Same plus lw_stall → ifid_flush=0. Without the macro → ifid_flush=0 always.
